dynamic_multi_bit_sreg: RTL and testbench
=========================================

Name: dynamic_multi_bit_sreg

Overview:
Runtime-programmable multi-bit delay line, the successor to the static fixed-depth shift register. Delay is selected per cycle through a tap address, from 1 to MAX_DEPTH clock-enable cycles. A per-sample valid bit travels alongside the data. A fill state machine suppresses output valid after reset and after any delay change, until the line holds a coherent sample history. Used for latency matching across pipelines whose latency is configured at runtime.

Parameters:
MAX_DEPTH, 32, maximum delay in ce-cycles; must be >= 2; ADDR_W = $clog2(MAX_DEPTH) is derived, not overridable.
WIDTH, 8, data width in bits; must be >= 1.
SRL_STYLE_VAL, "srl", srl_style attribute on the data array; one of register, srl, reg_srl, srl_reg, reg_srl_reg.

Ports:
clk  input  1  clock; all logic on its rising edge.
rst_n  input  1  synchronous reset, active low.
ce  input  1  clock enable; the line shifts only when ce=1.
dly  input  ADDR_W  requested delay minus one, so delay = dly+1 ce-cycles; dly >= MAX_DEPTH is clamped to MAX_DEPTH-1.
si  input  WIDTH  input sample.
si_vld  input  1  input sample valid.
so  output  WIDTH  delayed sample, tap dly_r of the data array.
so_vld  output  1  delayed valid, gated by the fill state.
primed  output  1  1 when state is RUN.

Behaviour:
- Data array sreg[0..MAX_DEPTH-1]:
  - WIDTH wide, carries the srl_style attribute, power-up initialised to 0.
  - Not reset, so SRL inference is preserved.
  - On ce=1: sreg[0] <= si and sreg[i] <= sreg[i-1].
- Valid array vld[0..MAX_DEPTH-1]:
  - Shifts in lockstep with sreg, inserting si_vld.
  - Cleared to all-0 by reset.
- dly_r:
  - Registered, clamped copy of dly, sampled every clk regardless of ce.
  - Reset loads clamp(dly).
- Outputs, without the optional feature:
  - so = sreg[dly_r] and raw_vld = vld[dly_r], both combinational from the registered tap.
  - so_vld = raw_vld & primed.
- Latency: a sample presented with ce=1 at cycle t appears on so after dly_r+1 ce-enabled edges. Example: dly_r=0 gives so at the next edge.
- FSM states: FILL and RUN. Fill counter fcnt is ADDR_W+1 bits wide.
- Reset:
  - state=FILL, fcnt=clamp(dly)+1, vld cleared.
  - so_vld=0, primed=0. so is not reset and shows the array contents (0 after configuration).
- FILL:
  - On ce=1, fcnt decrements.
  - When fcnt==1 and ce=1, go to RUN on that edge.
  - If fcnt==0, go to RUN immediately.
- RUN: stays in RUN while dly_r is unchanged.
- Delay change: whenever clamp(dly) != dly_r at a clk edge, in any state:
  - dly_r updates, state=FILL, fcnt=clamp(dly)+1.
  - so_vld is low from the next cycle until the new line has refilled.
- Change during FILL: restarts the count using the new value.
- Simultaneous change and ce=1: the shift happens, and the count loads the new value with no decrement on that edge.
- ce=0: array, vld and fcnt hold. dly_r and the FSM still react to dly changes.
- Samples already in the array are not discarded on a delay change. They are only masked while in FILL.
- Reset mid-stream: all valids are dropped. Data contents persist but are masked.

Optional Feature:
DSREG_OUT_REG_EN
- Defined:
  - Adds one output register stage: so and so_vld are registered on ce=1.
  - Latency becomes dly_r+2 ce-cycles.
  - Reset drives so=0 and so_vld=0.
  - The FILL count loads clamp(dly)+2.
  - primed is unregistered.
- Undefined: outputs are combinational from the tap as above, and the FILL count loads clamp(dly)+1.

Test Plan:
1. Reset with dly=3, then ce=1 and si=1,2,3,... with si_vld=1 every cycle -> so_vld=0 for 4 edges, then so=1,2,3,... with so_vld=1; primed rises at the 4th ce edge after reset.
2. dly=0 and si=0xA5 -> so=0xA5 one edge later; dly=MAX_DEPTH-1 -> 32-cycle delay; dly=40 with ADDR_W=5 is not representable, so use MAX_DEPTH=24, dly=30 -> clamped delay of 24.
3. In RUN with dly=7, change dly to 2 -> so_vld=0 for 3 ce-edges, then the stream resumes at delay 3 with no invalid gaps.
4. In FILL, ce toggled 1,0,1,0 -> fcnt decrements only on ce=1 edges; so and so_vld hold during ce=0.
5. si_vld pattern 1,0,1,1 at dly=4 -> so_vld shows 1,0,1,1 delayed by 5 after priming.
6. Reset asserted for 1 cycle mid-stream -> so_vld=0 and primed=0 on the next edge, with a refill of clamp(dly)+1 edges. With DSREG_OUT_REG_EN: so=0 after reset, and the scenario 1 latency is +1.

Source files
------------

// File: rtl/dynamic_multi_bit_sreg.sv
// Runtime-programmable delay line (1..MAX_DEPTH ce-cycles) with per-sample valid and fill masking.
// Optional macro DSREG_OUT_REG_EN adds a registered output stage (+1 ce-cycle latency).
module dynamic_multi_bit_sreg #(
  parameter int MAX_DEPTH     = 32,
  parameter int WIDTH         = 8,
  parameter     SRL_STYLE_VAL = "srl"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic [$clog2(MAX_DEPTH)-1:0] dly,
  input  logic [WIDTH-1:0]             si,
  input  logic                         si_vld,
  output logic [WIDTH-1:0]             so,
  output logic                         so_vld,
  output logic                         primed
);
  localparam int                ADDR_W   = $clog2(MAX_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(MAX_DEPTH);
  localparam logic [ADDR_W-1:0] TAP_MAX  = ADDR_W'(MAX_DEPTH - 1);
  localparam logic [ADDR_W:0]   FCNT_ONE = (ADDR_W+1)'(1);
`ifdef DSREG_OUT_REG_EN
  localparam logic [ADDR_W:0]   FILL_EXTRA = (ADDR_W+1)'(2);
`else
  localparam logic [ADDR_W:0]   FILL_EXTRA = (ADDR_W+1)'(1);
`endif

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_e;

  if (MAX_DEPTH < 2 || WIDTH < 1 ||
      (SRL_STYLE_VAL != "register" && SRL_STYLE_VAL != "srl" && SRL_STYLE_VAL != "reg_srl" &&
       SRL_STYLE_VAL != "srl_reg" && SRL_STYLE_VAL != "reg_srl_reg")) begin : g_bad_cfg
    $error("dynamic_multi_bit_sreg: unsupported parameter set");
  end

  function automatic logic [ADDR_W-1:0] clamp_dly(input logic [ADDR_W-1:0] d);
    if ({1'b0, d} >= DEPTH_L) begin
      return TAP_MAX;
    end else begin
      return d;
    end
  endfunction

  (* srl_style = SRL_STYLE_VAL *)
  logic [WIDTH-1:0]     sreg_q [MAX_DEPTH] = '{default: '0};
  logic [MAX_DEPTH-1:0] vld_q;
  logic [ADDR_W-1:0]    dly_q;
  logic [ADDR_W-1:0]    dly_d;
  logic [ADDR_W:0]      fcnt_q;
  logic [ADDR_W:0]      fill_load;
  state_e               state_q;
  logic                 primed_q;
  logic                 dly_chg;

  // Clamped tap request, change detect and fill-count reload value.
  always_comb begin
    dly_d     = clamp_dly(dly);
    dly_chg   = (dly_d != dly_q);
    fill_load = {1'b0, dly_d} + FILL_EXTRA;
  end

  // Data line: deliberately unreset so it can map onto shift-register primitives.
  always_ff @(posedge clk) begin
    if (ce) begin
      sreg_q[0] <= si;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        sreg_q[i] <= sreg_q[i-1];
      end
    end
  end

  // Valid line shifts in lockstep with the data and is dropped by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (ce) begin
      vld_q <= {vld_q[MAX_DEPTH-2:0], si_vld};
    end
  end

  // Tap register and fill FSM; any tap change restarts the fill count without decrementing.
  always_ff @(posedge clk) begin
    if (!rst_n || dly_chg) begin
      dly_q    <= dly_d;
      state_q  <= FILL;
      fcnt_q   <= fill_load;
      primed_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (fcnt_q == '0) begin
            state_q  <= RUN;
            primed_q <= 1'b1;
          end else if (ce) begin
            fcnt_q <= fcnt_q - FCNT_ONE;
            if (fcnt_q == FCNT_ONE) begin
              state_q  <= RUN;
              primed_q <= 1'b1;
            end
          end
        end
        RUN: begin
          primed_q <= 1'b1;
        end
        default: begin
          state_q  <= FILL;
          fcnt_q   <= fill_load;
          primed_q <= 1'b0;
        end
      endcase
    end
  end

  assign primed = primed_q;

`ifdef DSREG_OUT_REG_EN
  logic [WIDTH-1:0] so_q;
  logic             so_vld_q;
  logic             run_nxt;

  assign run_nxt = !dly_chg &&
                   ((state_q == RUN) || (fcnt_q == '0) || (ce && (fcnt_q == FCNT_ONE)));

  // Output stage; valid is re-qualified every clk so a tap change masks it even with ce low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      so_q     <= '0;
      so_vld_q <= 1'b0;
    end else begin
      if (ce) begin
        so_q <= sreg_q[dly_q];
      end
      so_vld_q <= (ce ? vld_q[dly_q] : so_vld_q) & run_nxt;
    end
  end

  assign so     = so_q;
  assign so_vld = so_vld_q;
`else
  assign so     = sreg_q[dly_q];
  assign so_vld = vld_q[dly_q] & primed_q;
`endif

endmodule

// File: tb/tb_dynamic_multi_bit_sreg.sv
// Scoreboarded bench for dynamic_multi_bit_sreg: a default instance and a MAX_DEPTH=24 instance
// share stimulus; a small reference model pushes expectations that are popped after each edge.
module tb_dynamic_multi_bit_sreg;
`ifdef DSREG_OUT_REG_EN
  localparam int EXTRA  = 2;
  localparam bit OUTREG = 1'b1;
`else
  localparam int EXTRA  = 1;
  localparam bit OUTREG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [4:0] dly;
  logic [7:0] si;
  logic       si_vld;
  logic [7:0] so_a, so_b;
  logic       so_vld_a, so_vld_b, primed_a, primed_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         k;
    logic [7:0] so;
    logic       vld;
    logic       prim;
  } exp_t;
  exp_t exp_q[$];

  int         depth_m[2] = '{32, 24};
  logic [7:0] hd[2][32];
  logic       hv[2][32];
  int         md[2];
  int         mf[2];
  logic [7:0] od[2];
  logic       ov[2];

  always #5 clk = ~clk;

  dynamic_multi_bit_sreg u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .dly(dly), .si(si), .si_vld(si_vld),
    .so(so_a), .so_vld(so_vld_a), .primed(primed_a)
  );

  dynamic_multi_bit_sreg #(.MAX_DEPTH(24), .WIDTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .dly(dly), .si(si), .si_vld(si_vld),
    .so(so_b), .so_vld(so_vld_b), .primed(primed_b)
  );

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h at %0t", tag, k, obs, expv, $time);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [7:0] d, input logic v);
    int         nd;
    logic [7:0] old_d;
    logic       old_v;
    logic       prim;
    exp_t       e;
    logic [7:0] o_so;
    logic       o_v;
    logic       o_p;
    rst_n  = r;
    ce     = c;
    si     = d;
    si_vld = v;
    for (int k = 0; k < 2; k++) begin
      nd    = (int'(dly) >= depth_m[k]) ? depth_m[k] - 1 : int'(dly);
      old_d = hd[k][md[k]];
      old_v = hv[k][md[k]];
      if (c) begin
        for (int i = 31; i > 0; i--) begin
          hd[k][i] = hd[k][i-1];
          hv[k][i] = hv[k][i-1];
        end
        hd[k][0] = d;
        hv[k][0] = v;
      end
      if (!r) begin
        for (int i = 0; i < 32; i++) hv[k][i] = 1'b0;
        md[k] = nd;
        mf[k] = nd + EXTRA;
      end else if (nd != md[k]) begin
        md[k] = nd;
        mf[k] = nd + EXTRA;
      end else if (c && mf[k] > 0) begin
        mf[k] = mf[k] - 1;
      end
      prim = (mf[k] == 0);
      if (!r) begin
        od[k] = 8'h00;
        ov[k] = 1'b0;
      end else begin
        if (c) od[k] = old_d;
        ov[k] = (c ? old_v : ov[k]) & prim;
      end
      e.k    = k;
      e.so   = OUTREG ? od[k] : hd[k][md[k]];
      e.vld  = OUTREG ? ov[k] : (hv[k][md[k]] & prim);
      e.prim = prim;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.k == 0) begin
        o_so = so_a; o_v = so_vld_a; o_p = primed_a;
      end else begin
        o_so = so_b; o_v = so_vld_b; o_p = primed_b;
      end
      chk("so", e.k, o_so, e.so);
      chk("so_vld", e.k, {7'd0, o_v}, {7'd0, e.vld});
      chk("primed", e.k, {7'd0, o_p}, {7'd0, e.prim});
    end
  endtask

  task automatic run(input int n, input logic v);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 8'($urandom), v);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        hd[k][i] = 8'h00;
        hv[k][i] = 1'b0;
      end
      md[k] = 0;
      mf[k] = 99;
      od[k] = 8'h00;
      ov[k] = 1'b0;
    end

    // Reset with delay 4, then a counting stream.
    dly = 5'd3;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, 8'(i), 1'b1);

    // Minimum delay, then maximum and clamped delays.
    dly = 5'd0;
    step(1'b1, 1'b1, 8'hA5, 1'b1);
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    step(1'b1, 1'b1, 8'h3C, 1'b1);
    dly = 5'd31;
    run(40, 1'b1);
    dly = 5'd30;
    run(30, 1'b1);

    // Shrinking the delay while running.
    dly = 5'd7;
    run(14, 1'b1);
    dly = 5'd2;
    run(8, 1'b1);

    // Clock-enable gaps during fill, change during fill, change together with ce.
    dly = 5'd5;
    step(1'b1, 1'b1, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    step(1'b1, 1'b0, 8'h44, 1'b1);
    dly = 5'd6;
    step(1'b1, 1'b0, 8'h55, 1'b1);
    step(1'b1, 1'b1, 8'h66, 1'b1);
    dly = 5'd9;
    step(1'b1, 1'b1, 8'h77, 1'b1);
    run(12, 1'b1);

    // Sparse valid pattern at delay 5.
    dly = 5'd4;
    run(8, 1'b1);
    step(1'b1, 1'b1, 8'hC1, 1'b1);
    step(1'b1, 1'b1, 8'hC2, 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b1);
    step(1'b1, 1'b1, 8'hC4, 1'b1);
    run(8, 1'b0);
    run(4, 1'b1);

    // One-cycle reset mid-stream, refill, then hold with ce low.
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    run(8, 1'b1);
    step(1'b1, 1'b0, 8'h01, 1'b1);
    step(1'b1, 1'b0, 8'h02, 1'b1);
    step(1'b1, 1'b0, 8'h03, 1'b1);
    run(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
